// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, flag bit positions and sequencer states.
package alu_pkg;

  localparam int unsigned NREQ    = 2;
  localparam logic        RR_INIT = 1'b1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit ALU producing a result and NZCV flags.
// Logic ops report C=V=0; illegal codes give result 0, Z=1 and err.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        err
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: carry out is set when there is no borrow.
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  // Decode the operation, then derive N and Z from whatever result was selected.
  always_comb begin
    result = '0;
    flags  = '0;
    err    = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result        = sum[31:0];
        flags[FLAG_C] = sum[32];
        flags[FLAG_V] = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result        = diff[31:0];
        flags[FLAG_C] = diff[32];
        flags[FLAG_V] = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_ORR: result = a | b;
      ALU_EOR: result = a ^ b;
      default: err = 1'b1;
    endcase
    flags[FLAG_N] = result[31];
    flags[FLAG_Z] = (result == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, IDLE/EXEC/DONE sequencing,
// registered response and the architectural NZCV flags register.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_s,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_s,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [3:0]  flags_q
);

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic [NREQ-1:0] grant;
  logic        accept;

  logic [2:0]  op_ctrl_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        op_s_q;
  logic        op_id_q;

  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        alu_err;

  // Round-robin grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant = '0;
    if (req0_valid && (!req1_valid || last_grant_q)) grant[0] = 1'b1;
    if (req1_valid && (!req0_valid || !last_grant_q)) grant[1] = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign rsp_valid  = (state_q == DONE);

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch the granted request and remember who won.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= RR_INIT;
      op_ctrl_q    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_s_q       <= 1'b0;
      op_id_q      <= 1'b0;
    end else if (accept) begin
      last_grant_q <= req1_ready;
      op_id_q      <= req1_ready;
      op_ctrl_q    <= req1_ready ? req1_ctrl : req0_ctrl;
      op_a_q       <= req1_ready ? req1_a    : req0_a;
      op_b_q       <= req1_ready ? req1_b    : req0_b;
      op_s_q       <= req1_ready ? req1_s    : req0_s;
    end
  end

  alu u_alu (
    .ctrl   (op_ctrl_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (alu_result),
    .flags  (alu_flags),
    .err    (alu_err)
  );

  // Capture the ALU outcome on EXEC -> DONE; logic ops leave C and V of flags_q alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      flags_q    <= '0;
    end else if (state_q == EXEC) begin
      rsp_id     <= op_id_q;
      rsp_result <= alu_result;
      rsp_flags  <= alu_flags;
      rsp_err    <= alu_err;
      if (op_s_q && !alu_err) begin
        flags_q[FLAG_N] <= alu_flags[FLAG_N];
        flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
        if (op_ctrl_q == ALU_ADD || op_ctrl_q == ALU_SUB) begin
          flags_q[FLAG_C] <= alu_flags[FLAG_C];
          flags_q[FLAG_V] <= alu_flags[FLAG_V];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: the monitor predicts grants, pushes expected responses on acceptance
// and pops/compares them while rsp_valid is high.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_s, req1_s;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags, flags_q;

  alu_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctrl  (req0_ctrl),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_s     (req0_s),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctrl  (req1_ctrl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_s     (req1_s),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .flags_q    (flags_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        err;
    logic [3:0]  fq;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  exp_t exp_q[$];
  logic grant_log[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   outstanding = 0;
  logic model_last = 1'b1;
  logic [3:0] model_flags = 4'b0000;

  task automatic check(input logic [63:0] act, input logic [63:0] req, input string name);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: plain integer arithmetic, signed overflow by comparing exact and wrapped sums.
  function automatic exp_t model(input logic id, input logic [2:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic s, input logic [3:0] fq_in);
    exp_t        e;
    logic [63:0] wide;
    longint      sa, sb, st;
    logic        c, v, arith, legal;
    e = '0;
    e.id = id;
    e.fq = fq_in;
    c = 1'b0; v = 1'b0; arith = 1'b0; legal = 1'b1; st = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctrl)
      3'd0: begin
        wide = 64'(a) + 64'(b);
        e.result = wide[31:0];
        c = wide[32];
        st = sa + sb;
        arith = 1'b1;
      end
      3'd1: begin
        e.result = a - b;
        c = (a >= b);
        st = sa - sb;
        arith = 1'b1;
      end
      3'd2: e.result = a & b;
      3'd3: e.result = a | b;
      3'd4: e.result = a ^ b;
      default: legal = 1'b0;
    endcase
    if (arith) v = (st != longint'($signed(e.result)));
    if (!legal) begin
      e.result = '0;
      e.err = 1'b1;
      e.flags = 4'b0100;
    end else begin
      e.flags = {e.result[31], e.result == 32'd0, c, v};
      if (s) e.fq = arith ? e.flags : {e.flags[3:2], fq_in[1:0]};
    end
    return e;
  endfunction

  // Monitor / scoreboard.
  initial begin
    logic e0, e1, id;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        check(64'(rsp_valid), 64'(0), "reset_rsp_valid");
        check(64'(flags_q), 64'(0), "reset_flags_q");
        check(64'({rsp_id, rsp_err, rsp_flags, rsp_result}), 64'(0), "reset_rsp_regs");
        continue;
      end
      e0 = !outstanding && req0_valid && (!req1_valid || model_last);
      e1 = !outstanding && req1_valid && (!req0_valid || !model_last);
      check(64'({req1_ready, req0_ready}), 64'({e1, e0}), "ready");
      if (!outstanding) begin
        check(64'(rsp_valid), 64'(0), "idle_rsp_valid");
        check(64'(flags_q), 64'(model_flags), "idle_flags_q");
      end
      if (e0 || e1) begin
        id = e1;
        if (id) e = model(1'b1, req1_ctrl, req1_a, req1_b, req1_s, model_flags);
        else    e = model(1'b0, req0_ctrl, req0_a, req0_b, req0_s, model_flags);
        exp_q.push_back(e);
        grant_log.push_back(id);
        model_flags = e.fq;
        model_last  = id;
        outstanding = 1'b1;
        have_cur    = 1'b0;
        accept_cyc  = cyc;
      end else if (outstanding) begin
        if (cyc == accept_cyc + 1) begin
          check(64'(rsp_valid), 64'(0), "exec_rsp_valid");
        end else if (!rsp_valid) begin
          check(64'(rsp_valid), 64'(1), "rsp_valid_held");
        end else begin
          if (!have_cur) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_rsp");
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1'b1;
              check(64'(cyc), 64'(accept_cyc + 2), "latency");
            end
          end
          if (have_cur) begin
            check(64'(rsp_id), 64'(cur.id), "rsp_id");
            check(64'(rsp_result), 64'(cur.result), "rsp_result");
            check(64'(rsp_flags), 64'(cur.flags), "rsp_flags");
            check(64'(rsp_err), 64'(cur.err), "rsp_err");
            check(64'(flags_q), 64'(cur.fq), "rsp_flags_q");
          end
          if (rsp_ready) begin
            outstanding = 1'b0;
            have_cur = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_ops();
    req0_ctrl = 3'($urandom_range(0, 7)); req1_ctrl = 3'($urandom_range(0, 7));
    req0_a = rand_word(); req0_b = rand_word(); req1_a = rand_word(); req1_b = rand_word();
    req0_s = 1'($urandom_range(0, 1)); req1_s = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic id, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
    if (id) begin
      req1_ctrl = ctrl; req1_a = a; req1_b = b; req1_s = s; req1_valid = 1'b1;
    end else begin
      req0_ctrl = ctrl; req0_a = a; req0_b = b; req0_s = s; req0_valid = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        return;
      end
    end
    fail_now("issue_timeout");
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!outstanding) return;
    end
    fail_now("wait_idle_timeout");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    outstanding = 1'b0; have_cur = 1'b0;
    model_flags = 4'b0000; model_last = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Stimulus.
  initial begin
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_ctrl = 0; req1_ctrl = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_s = 0; req1_s = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    issue(1'b0, 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1);
    wait_idle();
    check(64'(flags_q), 64'(4'b1001), "add_ovf_flags_q");
    issue(1'b1, 3'b001, 32'd5, 32'd5, 1'b1);
    wait_idle();
    check(64'(flags_q), 64'(4'b0110), "sub_eq_flags_q");
    issue(1'b1, 3'b010, 32'hF0, 32'h0F, 1'b1);
    wait_idle();
    check(64'(flags_q), 64'(4'b0110), "and_keeps_c");
    issue(1'b0, 3'b101, 32'h1234, 32'h5678, 1'b1);
    wait_idle();
    check(64'(flags_q), 64'(4'b0110), "illegal_keeps_flags");

    // Backpressure: hold rsp_ready low while both requesters keep offering.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b100, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1);
    rand_ops();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Both valid every cycle from reset: grants must alternate starting at req0.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) begin
      rand_ops();
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (grant_log.size() < 4) fail_now("rr_grant_count");
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check(64'(grant_log[i]), 64'(i % 2), "rr_grant_order");
    wait_idle();

    // Reset while the op is in EXEC: it must vanish without a response.
    issue(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h2, 1'b1);
    do_reset();
    check(64'(rsp_valid), 64'(0), "rst_exec_rsp_valid");
    check(64'(flags_q), 64'(0), "rst_exec_flags_q");
    repeat (10) @(posedge clk);
    #1;

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) fail_now("scoreboard_not_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
